instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the LEGv8 core, directly upstream of the control decoder. It owns the program counter and issues one word fetch at a time to instruction memory over a request/response handshake. It holds the returned 32-bit word for the decoder and, when the word is consumed, computes the next PC from the decoder's `BrTaken`/`UncondBr` outputs.

## Interface
- `PC_W`, 64, program counter and fetch address width
- `RESET_PC`, 64'h0, PC value loaded on reset; must be 4-byte aligned
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  PC_W  fetch byte address, equal to `pc`
- `imem_ready`  in  1  memory accepts the request in this cycle
- `imem_rvalid`  in  1  fetch data valid
- `imem_rdata`  in  32  fetched instruction word
- `instruction`  out  32  held instruction, fed to the control decoder
- `instr_valid`  out  1  `instruction` is valid
- `instr_ready`  in  1  the execute/decode side consumes `instruction` this cycle
- `BrTaken`  in  1  from the decoder; sampled only on consume
- `UncondBr`  in  1  from the decoder; sampled only on consume and only when `BrTaken`=1
- `pc`  out  PC_W  address of the held or in-flight instruction

## Operation
- The FSM has four states: IDLE, REQ, WAIT, HOLD.
- **IDLE**: entered on reset. Moves to REQ on the first clock edge after `reset_n` rises.
- **REQ**:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - The request is accepted when `imem_req` and `imem_ready` are both 1 at a clock edge; the FSM then moves to WAIT.
  - `imem_addr` stays stable until the request is accepted.
- **WAIT**:
  - `imem_req`=0.
  - When `imem_rvalid`=1, capture `imem_rdata` into `instruction` and move to HOLD.
  - `imem_rvalid` is ignored in every state other than WAIT.
- **HOLD**:
  - `instr_valid`=1, and `instruction` is stable until consumed.
  - The word is consumed when `instr_valid` and `instr_ready` are both 1 at a clock edge. On that edge `pc` is updated and the FSM moves to REQ.
- **Next-PC rule** (applied on consume):
  - `BrTaken`=0: `pc` + 4.
  - `BrTaken`=1 and `UncondBr`=1: `pc` + (sign-extend(`instruction[25:0]`) << 2).
  - `BrTaken`=1 and `UncondBr`=0: `pc` + (sign-extend(`instruction[23:5]`) << 2).
- **Arithmetic**: all additions are modulo 2^PC_W. Wrap-around past all-ones, or below zero, wraps silently. The two LSBs of `pc` are always 0.
- **X handling**: `BrTaken` or `UncondBr` may be X while no consume is occurring and must not corrupt state. A consume with `BrTaken`=X (undefined opcode) is a bench error, not a design requirement.
- **Outstanding requests**: only one request is outstanding at a time. No flush is needed because nothing is speculative.

## Timing
- **Reset values**: state=IDLE, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instruction`=32'h0, `instr_valid`=0.
- **Reset mid-operation**: asserting `reset_n`=0 in any state immediately forces all reset values. A response that arrives after reset is dropped, because the FSM is not in WAIT.
- **Best-case cycle sequence**:
  - Cycle 0: `reset_n` rises.
  - Cycle 1: `imem_req`=1.
  - If `imem_ready`=1 in cycle 1, then WAIT in cycle 2.
  - If `imem_rvalid`=1 in cycle 2, then `instr_valid`=1 in cycle 3.
  - If consumed in cycle 3, `imem_req`=1 for the next PC in cycle 4.
- Fetch-to-fetch throughput is therefore 3 cycles minimum.
- **Registered outputs**: `instr_valid`, `instruction`, `imem_req`, `imem_addr` and `pc` are all registered. The only combinational inputs to state are `BrTaken` and `UncondBr`, and only on the consume edge.
- **Stalls**:
  - `imem_ready`=0 holds the FSM in REQ indefinitely.
  - `instr_ready`=0 holds it in HOLD with `instruction` unchanged.

## Structure
- Shared package `cpu_pkg` holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD);
  - `INSTR_W`=32;
  - the default `PC_W`;
  - the field-position constants for imm26 ([25:0]) and imm19 ([23:5]).
- One sub-module, `br_target_calc`, is combinational. Its inputs are `pc`, `instruction`, `BrTaken` and `UncondBr`; its output is `next_pc`. It contains the sign extension, the shift and the adder, and is reused later by the pipelined core.

## Test plan
- **Reset and first fetch**: `RESET_PC`=0 and `imem_ready`=1.
  - Required: `imem_req` is 1 in the first cycle after reset release, with `imem_addr`=0.
  - Word 0x8B000000 returned the next cycle gives `instr_valid`=1 and `instruction`=0x8B000000 one cycle later.
- **Sequential fetch**: three consumes with `BrTaken`=0 starting at `pc`=0x100. Required: fetch addresses 0x104, 0x108, 0x10C.
- **Unconditional branch**:
  - B word 0x17FFFFFE at `pc`=0x200, consumed with `BrTaken`=1 and `UncondBr`=1. Required: next `imem_addr`=0x1F8.
  - imm26=0x3FFFFFE gives -8.
- **Conditional branch**: CBZ word 0xB4000040 (imm19=2) at `pc`=0x40, with `BrTaken`=1 and `UncondBr`=0. Required: next address 0x48. The same word with `BrTaken`=0 gives 0x44.
- **Stalls**:
  - `imem_ready` held 0 for 5 cycles: `imem_req` stays 1 and `imem_addr` is stable.
  - `instr_ready` held 0 for 4 cycles: `instruction` and `pc` are unchanged.
  - A spurious `imem_rvalid` during HOLD is ignored.
- **Reset in WAIT, and wrap-around**:
  - `reset_n`=0 while in WAIT, with `imem_rvalid`=1 arriving the cycle after release. Required: the word is dropped and the fetch restarts at `RESET_PC`.
  - `pc`=0xFFFF_FFFF_FFFF_FFFC with `BrTaken`=0. Required: next `pc`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and constants for the LEGv8 fetch path.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int INSTR_W      = 32;
   localparam int PC_W_DEFAULT = 64;

   // Immediate field positions within the instruction word
   localparam int IMM26_MSB = 25;
   localparam int IMM26_LSB = 0;
   localparam int IMM19_MSB = 23;
   localparam int IMM19_LSB = 5;
   localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
   localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_if
//  Purpose  : Memory request/response and decoder handshake of the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
   parameter int PC_W = cpu_pkg::PC_W_DEFAULT
);
   logic                        imem_req;
   logic [PC_W-1:0]             imem_addr;
   logic                        imem_ready;
   logic                        imem_rvalid;
   logic [cpu_pkg::INSTR_W-1:0] imem_rdata;
   logic [cpu_pkg::INSTR_W-1:0] instruction;
   logic                        instr_valid;
   logic                        instr_ready;
   logic                        BrTaken;
   logic                        UncondBr;
   logic [PC_W-1:0]             pc;

   modport master (
      output imem_req, imem_addr, instruction, instr_valid, pc,
      input  imem_ready, imem_rvalid, imem_rdata, instr_ready, BrTaken, UncondBr
   );

   modport slave (
      input  imem_req, imem_addr, instruction, instr_valid, pc,
      output imem_ready, imem_rvalid, imem_rdata, instr_ready, BrTaken, UncondBr
   );
endinterface
`default_nettype wire

// File: rtl/br_target_calc.sv
`default_nettype none
// ============================================================================
//  Module   : br_target_calc
//  Purpose  : Combinational next-PC: sequential, B (imm26) or CB (imm19) target.
//  Revision : 1.0 - initial release
// ============================================================================
module br_target_calc
   import cpu_pkg::*;
#(
   parameter int PC_W = PC_W_DEFAULT
) (
   input  logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               BrTaken,
   input  logic               UncondBr,
   output logic [PC_W-1:0]    next_pc
);

   logic [PC_W-1:0] w_off_uncond;
   logic [PC_W-1:0] w_off_cond;
   logic [PC_W-1:0] w_offset;
   logic            w_unused_opcode;

   // Word offsets become byte offsets by appending two zero bits
   assign w_off_uncond = {{(PC_W-IMM26_W-2){instruction[IMM26_MSB]}},
                          instruction[IMM26_MSB:IMM26_LSB], 2'b00};
   assign w_off_cond   = {{(PC_W-IMM19_W-2){instruction[IMM19_MSB]}},
                          instruction[IMM19_MSB:IMM19_LSB], 2'b00};

   always_comb begin
      w_offset = PC_W'(4);
      if (BrTaken) begin
         w_offset = UncondBr ? w_off_uncond : w_off_cond;
      end
   end

   // Wraps modulo 2^PC_W; alignment is preserved since every offset is a multiple of 4
   assign next_pc = pc + w_offset;

   assign w_unused_opcode = ^instruction[INSTR_W-1:IMM26_MSB+1];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : LEGv8 fetch stage: owns the PC, one outstanding fetch at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset_n,
   instr_fetch_if.master  bus
);

   fetch_state_t       r_state;
   logic [PC_W-1:0]    r_pc;
   logic               r_req;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic [PC_W-1:0]    w_next_pc;

   br_target_calc #(
      .PC_W (PC_W)
   ) u_br_target_calc (
      .pc          (r_pc),
      .instruction (r_instr),
      .BrTaken     (bus.BrTaken),
      .UncondBr    (bus.UncondBr),
      .next_pc     (w_next_pc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= REQ;
               r_req   <= 1'b1;
            end
            REQ: begin
               if (r_req && bus.imem_ready) begin
                  r_state <= WAIT;
                  r_req   <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  r_state <= HOLD;
                  r_instr <= bus.imem_rdata;
                  r_valid <= 1'b1;
               end
            end
            HOLD: begin
               // Branch inputs only matter here, so X outside a consume is harmless
               if (r_valid && bus.instr_ready) begin
                  r_state <= REQ;
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = r_req;
   assign bus.imem_addr   = r_pc;
   assign bus.pc          = r_pc;
   assign bus.instruction = r_instr;
   assign bus.instr_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Scoreboard bench for instr_fetch with directed fetch/branch vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } cons_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [63:0] aq[$];
   cons_t       cq[$];

   instr_fetch_if #(.PC_W(64)) bus ();

   instr_fetch #(
      .PC_W     (64),
      .RESET_PC (64'h0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: handshakes are visible at the negedge preceding the edge that takes them
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.imem_req && bus.imem_ready) begin
            if (aq.size() == 0) chk("unexpected_fetch", bus.imem_addr, 64'hx);
            else chk("fetch_addr", bus.imem_addr, aq.pop_front());
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (cq.size() == 0) begin
               chk("unexpected_consume", bus.pc, 64'hx);
            end else begin
               cons_t c;
               c = cq.pop_front();
               chk("consume_pc", bus.pc, c.pc);
               chk("consume_instr", {32'h0, bus.instruction}, {32'h0, c.instr});
            end
         end
      end
   end

   task automatic fetch_one(input logic [63:0] a, input logic [31:0] w,
                            input int rdy_wait, input int ir_wait,
                            input logic bt, input logic ub);
      int n;
      cons_t c;
      n = 0;
      c.pc = a;
      c.instr = w;
      aq.push_back(a);
      cq.push_back(c);
      while (bus.imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (bus.imem_req !== 1'b1) begin
         chk("req_timeout", {63'h0, bus.imem_req}, 64'h1);
         return;
      end
      for (int i = 0; i < rdy_wait; i++) begin
         bus.imem_ready = 1'b0;
         step();
         chk("stall_req", {63'h0, bus.imem_req}, 64'h1);
         chk("stall_addr", bus.imem_addr, a);
      end
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      chk("wait_req_low", {63'h0, bus.imem_req}, 64'h0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = w;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      chk("instr_valid", {63'h0, bus.instr_valid}, 64'h1);
      bus.BrTaken  = bt;
      bus.UncondBr = ub;
      for (int i = 0; i < ir_wait; i++) begin
         bus.instr_ready = 1'b0;
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = ~w;
         step();
         chk("hold_instr", {32'h0, bus.instruction}, {32'h0, w});
         chk("hold_pc", bus.pc, a);
      end
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      bus.BrTaken     = 1'b0;
      bus.UncondBr    = 1'b0;
      chk("post_consume_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("post_consume_req", {63'h0, bus.imem_req}, 64'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.instr_ready = 1'b0;
      bus.BrTaken     = 1'b0;
      bus.UncondBr    = 1'b0;

      repeat (3) step();
      chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
      chk("rst_addr", bus.imem_addr, 64'h0);
      chk("rst_pc", bus.pc, 64'h0);
      chk("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("rst_instr", {32'h0, bus.instruction}, 64'h0);

      reset_n = 1'b1;
      step();
      chk("first_req", {63'h0, bus.imem_req}, 64'h1);
      chk("first_addr", bus.imem_addr, 64'h0);

      // Walk the PC through the directed targets using hand-encoded branches
      fetch_one(64'h0,   32'h8B000000, 0, 0, 1'b0, 1'b0);  // -> 0x4
      fetch_one(64'h4,   32'h1400000F, 0, 0, 1'b1, 1'b1);  // B +0x3C -> 0x40
      fetch_one(64'h40,  32'hB4000040, 0, 0, 1'b1, 1'b0);  // CBZ +8 -> 0x48
      fetch_one(64'h48,  32'h17FFFFFE, 0, 0, 1'b1, 1'b1);  // B -8 -> 0x40
      fetch_one(64'h40,  32'hB4000040, 0, 0, 1'b0, 1'b0);  // not taken -> 0x44
      fetch_one(64'h44,  32'h1400002F, 0, 0, 1'b1, 1'b1);  // B +0xBC -> 0x100
      fetch_one(64'h100, 32'h8B000000, 5, 0, 1'b0, 1'b0);  // -> 0x104
      fetch_one(64'h104, 32'h8B010020, 0, 4, 1'b0, 1'b0);  // -> 0x108
      fetch_one(64'h108, 32'h8B020041, 0, 0, 1'b0, 1'b0);  // -> 0x10C
      fetch_one(64'h10C, 32'h1400003D, 0, 0, 1'b1, 1'b1);  // B +0xF4 -> 0x200
      fetch_one(64'h200, 32'h17FFFFFE, 0, 0, 1'b1, 1'b1);  // B -8 -> 0x1F8
      fetch_one(64'h1F8, 32'h17FFFF81, 0, 0, 1'b1, 1'b1);  // B -0x1FC -> ...FFC
      fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h8B000000, 0, 0, 1'b0, 1'b0); // wraps -> 0

      // Reset while a response is outstanding
      chk("pre_rst_addr", bus.imem_addr, 64'h0);
      aq.push_back(64'h0);
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      chk("rstw_in_wait", {63'h0, bus.imem_req}, 64'h0);
      reset_n = 1'b0;
      #1;
      chk("rstw_req", {63'h0, bus.imem_req}, 64'h0);
      chk("rstw_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("rstw_instr", {32'h0, bus.instruction}, 64'h0);
      step();
      reset_n = 1'b1;
      step();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEADBEEF;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      chk("drop_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("drop_instr", {32'h0, bus.instruction}, 64'h0);
      chk("restart_req", {63'h0, bus.imem_req}, 64'h1);
      chk("restart_addr", bus.imem_addr, 64'h0);
      fetch_one(64'h0, 32'h91000421, 0, 0, 1'b0, 1'b0);  // -> 0x4
      chk("final_pc", bus.pc, 64'h4);

      repeat (2) step();
      chk("aq_empty", 64'(aq.size()), 64'h0);
      chk("cq_empty", 64'(cq.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
